shift_reg_param: RTL

Parametrised successor of the 4-bit four-mode shift register. Adds configurable width and shift direction, a clock enable, a self-timed parallel-to-serial burst engine, and a word-complete strobe for serial-to-parallel capture. It sits between serial links and word-wide datapaths as a general-purpose serializer/deserializer.

---
 rtl/shift_reg_pkg.sv | 16 +
 rtl/shift_reg_param_if.sv | 35 +++
 rtl/shift_reg_bitcnt.sv | 47 ++++
 rtl/shift_reg_param.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the parametrised shift register: operating modes and burst FSM states.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    OP_SISO = 2'd0,
    OP_PISO = 2'd1,
    OP_SIPO = 2'd2,
    OP_PIPO = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/shift_reg_param_if.sv
// Control/data bundle of shift_reg_param. The ROT input exists only when
// SHIFT_REG_PARAM_ROTATE_EN is defined.
interface shift_reg_param_if #(
  parameter int WIDTH = 8
);
  import shift_reg_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  op_e              op;
  logic             d;
  logic [WIDTH-1:0] ll_in;
  logic             q;
  logic [WIDTH-1:0] ll_out;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic             word_vld;

`ifdef SHIFT_REG_PARAM_ROTATE_EN
  logic rot;

  modport master (output en, op, d, ll_in, rot,
                  input  q, ll_out, cnt, busy, done, word_vld);
  modport slave  (input  en, op, d, ll_in, rot,
                  output q, ll_out, cnt, busy, done, word_vld);
`else
  modport master (output en, op, d, ll_in,
                  input  q, ll_out, cnt, busy, done, word_vld);
  modport slave  (input  en, op, d, ll_in,
                  output q, ll_out, cnt, busy, done, word_vld);
`endif

endinterface

// File: rtl/shift_reg_bitcnt.sv
// Saturating bit counter (clear > load > inc/dec) with zero, one and last-bit flags
// used to time burst completion and word capture.
module shift_reg_bitcnt #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          is_zero,
  output logic          is_one,
  output logic          is_last
);

  logic [CW-1:0] cnt_d, cnt_q;

  // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != CW'(WIDTH))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == CW'(1));
  assign is_last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_reg_param.sv
// Parametrised SISO/PISO/SIPO/PIPO shift register with self-timed PISO burst.
// Define SHIFT_REG_PARAM_ROTATE_EN to add the ROT recirculation input.
module shift_reg_param
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_reg_param_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  op_e              prev_op_q, prev_op_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] ll_out_q, ll_out_d;
  logic             q_q, q_d;
  logic             done_q, done_d;
  logic             word_vld_q, word_vld_d;

  logic             cnt_clr, cnt_load, cnt_inc, cnt_dec;
  logic [CW-1:0]    cnt_load_val, cnt;
  logic             cnt_is_zero, cnt_is_one, cnt_is_last;
  logic             out_bit, rot_en, mode_chg;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic fill);
    if (LSB_FIRST) return {fill, v[WIDTH-1:1]};
    return {v[WIDTH-2:0], fill};
  endfunction

`ifdef SHIFT_REG_PARAM_ROTATE_EN
  assign rot_en = bus.rot;
`else
  assign rot_en = 1'b0;
`endif

  assign out_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign mode_chg = (bus.op != prev_op_q);

  shift_reg_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_zero  (cnt_is_zero),
    .is_one   (cnt_is_one),
    .is_last  (cnt_is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      unique case (state_q)
        ST_IDLE:  if (bus.op == OP_PISO) state_d = ST_BURST;
        ST_BURST: if (cnt_is_one)        state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and strobes; OP and LL_IN are only looked at outside a burst.
  always_comb begin
    shreg_d      = shreg_q;
    ll_out_d     = ll_out_q;
    q_d          = q_q;
    prev_op_d    = prev_op_q;
    done_d       = 1'b0;
    word_vld_d   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    if (bus.en) begin
      if (state_q == ST_BURST) begin
        q_d     = out_bit;
        shreg_d = shift_in(shreg_q, rot_en ? out_bit : 1'b0);
        cnt_dec = !cnt_is_zero;
        done_d  = cnt_is_one;
      end else begin
        prev_op_d = bus.op;
        unique case (bus.op)
          OP_SISO: begin
            q_d     = out_bit;
            shreg_d = shift_in(shreg_q, rot_en ? out_bit : bus.d);
            cnt_clr = 1'b1;
          end
          OP_PISO: begin
            shreg_d      = bus.ll_in;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(WIDTH);
          end
          OP_SIPO: begin
            shreg_d = shift_in(shreg_q, bus.d);
            // A fresh mode starts a new word with this bit as its first one.
            if (mode_chg) begin
              cnt_load     = 1'b1;
              cnt_load_val = CW'(1);
            end else if (cnt_is_last) begin
              ll_out_d   = shreg_d;
              word_vld_d = 1'b1;
              cnt_clr    = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
          OP_PIPO: begin
            ll_out_d = bus.ll_in;
            cnt_clr  = 1'b1;
          end
          default: cnt_clr = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      ll_out_q   <= '0;
      q_q        <= 1'b0;
      done_q     <= 1'b0;
      word_vld_q <= 1'b0;
      prev_op_q  <= OP_SISO;
    end else begin
      shreg_q    <= shreg_d;
      ll_out_q   <= ll_out_d;
      q_q        <= q_d;
      done_q     <= done_d;
      word_vld_q <= word_vld_d;
      prev_op_q  <= prev_op_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.ll_out   = ll_out_q;
  assign bus.cnt      = cnt;
  assign bus.busy     = (state_q == ST_BURST);
  assign bus.done     = done_q;
  assign bus.word_vld = word_vld_q;

endmodule
